// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned LEN_W = $clog2(MAX_LEN_DEF + 1);

  // Debug view of the fill counter; EMPTY/FILLING/ARMED relative to the active length.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_ARMED   = 2'd2
  } fill_state_e;

  function automatic int unsigned clamp_len(input int unsigned len_in,
                                            input int unsigned max_len);
    return (len_in > max_len) ? max_len : len_in;
  endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// Masked comparator: hit when the low len bits of win equal those of pattern (never for len 0).
module seq_det_cmp #(
  parameter  int unsigned MAX_LEN = 8,
  localparam int unsigned LenW    = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] win_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LenW-1:0]    len_i,
  output logic               hit_o
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      mask[i] = (i < int'(len_i));
    end
    hit_o = (len_i != '0) && (((win_i ^ pattern_i) & mask) == '0);
  end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable Mealy sequence detector with valid strobe and overlap select.
// Define SEQ_DET_COUNT_EN to add the saturating match_cnt output.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter  int unsigned        MAX_LEN     = 8,
  parameter  logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_0001),
  parameter  int unsigned        DEF_LEN     = 4,
`ifdef SEQ_DET_COUNT_EN
  parameter  int unsigned        CNT_W       = 16,
`endif
  localparam int unsigned        LenW        = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x,
  input  logic               x_valid,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LenW-1:0]    len_in,
  output logic               z,
  output logic [LenW-1:0]    fill
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  localparam logic [LenW-1:0] DefLenClamped = LenW'(clamp_len(DEF_LEN, MAX_LEN));

  // The oldest history bit would only ever be shifted out, so MAX_LEN-1 bits suffice.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LenW-1:0]    fill_q, fill_d, fill_next;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LenW-1:0]    len_q, len_d;
  logic [MAX_LEN-1:0] win;
  logic               hit;
  fill_state_e        state;

  assign win  = {hist_q, x};
  assign fill = fill_q;

  seq_det_cmp #(
    .MAX_LEN (MAX_LEN)
  ) u_cmp (
    .win_i     (win),
    .pattern_i (pattern_q),
    .len_i     (len_q),
    .hit_o     (hit)
  );

  always_comb begin
    state = ST_FILLING;
    if (fill_q >= len_q) begin
      state = ST_ARMED;
    end else if (fill_q == '0) begin
      state = ST_EMPTY;
    end

    unique case (state)
      ST_EMPTY, ST_FILLING: fill_next = fill_q + LenW'(1);
      ST_ARMED:             fill_next = fill_q;
      default:              fill_next = fill_q;
    endcase

    z = x_valid & ~pat_load & hit & (fill_next >= len_q);

    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    if (pat_load) begin
      pattern_d = pat_in;
      len_d     = LenW'(clamp_len(32'(len_in), MAX_LEN));
      hist_d    = '0;
      fill_d    = '0;
    end else if (x_valid) begin
      hist_d = win[MAX_LEN-2:0];
      // Non-overlapping mode demands len fresh bits before the next match.
      fill_d = (z && !overlap) ? '0 : fill_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= DEF_PATTERN;
      len_q     <= DefLenClamped;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
    end
  end

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (pat_load) begin
      cnt_q <= '0;
    end else if (z && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule
